// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM front-end: FSM state encoding,
// command opcodes and the command frame length.
package spi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int unsigned CMD_BITS = 10;

endpackage

// File: rtl/spi_tx_serializer.sv
// Loads a RAM read word on strobe and shifts it MSB-first onto miso,
// pulsing tx_done for one cycle once the last bit has been driven.
module spi_tx_serializer #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              tx_done
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            active  <= 1'b0;
            miso    <= 1'b0;
            tx_done <= 1'b0;
        end else if (clr) begin
            shreg   <= '0;
            cnt     <= '0;
            active  <= 1'b0;
            miso    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (load) begin
                shreg  <= data;
                cnt    <= '0;
                active <= 1'b1;
                miso   <= 1'b0;
            end else if (active) begin
                miso  <= shreg[DATA_W-1];
                shreg <= {shreg[DATA_W-2:0], 1'b0};
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    active  <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                miso <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI slave sequencer: decodes MOSI command frames into RAM commands and
// returns RAM read data on MISO once a read address has been loaded.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam logic [3:0] LAST_BIT = 4'(ADDR_SIZE + 1);

    state_t             state;
    logic               rd_addr_loaded;
    logic [3:0]         bit_cnt;
    // Holds the first ADDR_SIZE+1 bits; the final bit goes straight into rx_data.
    logic [ADDR_SIZE:0] rx_shift;
    logic               done;
    logic               tx_started;
    logic               tx_load;
    logic               tx_done;

    assign tx_load = !ss_n && (state == READ_DATA) && done && !tx_started && tx_valid;

    spi_tx_serializer #(
        .DATA_W (ADDR_SIZE)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .clr     (ss_n),
        .load    (tx_load),
        .data    (tx_data),
        .miso    (miso),
        .tx_done (tx_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rd_addr_loaded <= 1'b0;
            bit_cnt        <= '0;
            rx_shift       <= '0;
            done           <= 1'b0;
            tx_started     <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            // A completed readout clears the flag even if ss_n rises on this edge.
            if (tx_done) begin
                rd_addr_loaded <= 1'b0;
            end
            if (ss_n) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                done       <= 1'b0;
                tx_started <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CHK_CMD;
                        bit_cnt <= '0;
                        done    <= 1'b0;
                    end
                    CHK_CMD: begin
                        if (!mosi) begin
                            state <= WRITE;
                        end else if (rd_addr_loaded) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!done) begin
                            rx_shift <= {rx_shift[ADDR_SIZE-1:0], mosi};
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {rx_shift, mosi};
                                rx_valid <= 1'b1;
                                done     <= 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_loaded <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (tx_load) begin
                            tx_started <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: drives SPI frames edge by edge and
// checks rx strobes, MISO readout, the read-address flag and abort paths.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    int unsigned errors = 0;
    int unsigned checks = 0;

    spi_ram_ctrl #(
        .ADDR_SIZE (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs E0..E11 (or aborts by raising ss_n on the edge after nbits data bits).
    task automatic frame(input logic sel, input logic [9:0] w, input int nbits,
                         input state_t exp_state);
        ss_n = 1'b0;
        mosi = 1'b0;
        tick();
        mosi = sel;
        tick();
        chk("route", 16'(dut.state), 16'(exp_state));
        for (int i = 0; i < nbits; i++) begin
            mosi = w[9-i];
            tick();
            if (i < 9) begin
                chk("rxv_mid", 16'(rx_valid), 16'd0);
            end else begin
                chk("rxv_e11", 16'(rx_valid), 16'd1);
                chk("rx_data", 16'(rx_data), 16'(w));
            end
        end
        if (nbits < 10) begin
            mosi = w[9-nbits];
            ss_n = 1'b1;
            tick();
            chk("abort_rxv", 16'(rx_valid), 16'd0);
            chk("abort_idle", 16'(dut.state), 16'(IDLE));
        end
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
        chk("rxv_e12", 16'(rx_valid), 16'd0);
    endtask

    // Called right after E11 of a READ_DATA frame; tx_valid is sampled at E12+dly.
    task automatic read_back(input int dly, input logic [7:0] data, input logic [7:0] exp);
        tx_data = data;
        for (int k = 0; k < dly; k++) begin
            tick();
            chk("miso_wait", 16'(miso), 16'd0);
        end
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk("miso_et", 16'(miso), 16'd0);
        chk("rxv_single", 16'(rx_valid), 16'd0);
        for (int b = 7; b >= 0; b--) begin
            tick();
            chk("miso_bit", 16'(miso), 16'(exp[b]));
        end
        tick();
        chk("miso_tail", 16'(miso), 16'd0);
        chk("flag_clr", 16'(dut.rd_addr_loaded), 16'd0);
        tick();
        chk("miso_hold", 16'(miso), 16'd0);
        ss_n = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_miso", 16'(miso), 16'd0);
        chk("rst_rxv", 16'(rx_valid), 16'd0);
        chk("rst_rxd", 16'(rx_data), 16'd0);
        chk("rst_state", 16'(dut.state), 16'(IDLE));
        chk("rst_flag", 16'(dut.rd_addr_loaded), 16'd0);

        // Asynchronous reset in the middle of a write frame
        ss_n = 1'b0;
        tick();
        mosi = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("arst_state", 16'(dut.state), 16'(IDLE));
        chk("arst_cnt", 16'(dut.bit_cnt), 16'd0);
        chk("arst_rxv", 16'(rx_valid), 16'd0);
        chk("arst_miso", 16'(miso), 16'd0);
        ss_n = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        frame(1'b0, 10'h0A5, 10, WRITE);
        end_frame();
        // tx_valid outside a read wait phase must not disturb miso
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        frame(1'b0, 10'h13C, 10, WRITE);
        chk("txv_ignored", 16'(miso), 16'd0);
        tx_valid = 1'b0;
        end_frame();
        chk("txv_ignored2", 16'(miso), 16'd0);

        frame(1'b1, 10'h2A5, 10, READ_ADD);
        chk("flag_set", 16'(dut.rd_addr_loaded), 16'd1);
        end_frame();
        frame(1'b1, 10'h300, 10, READ_DATA);
        read_back(0, 8'h3C, 8'h3C);

        // Flag routing with a slow RAM on the read
        frame(1'b1, 10'h211, 10, READ_ADD);
        end_frame();
        frame(1'b1, 10'h3FF, 10, READ_DATA);
        read_back(5, 8'hA5, 8'hA5);
        frame(1'b1, 10'h2C3, 10, READ_ADD);
        end_frame();
        chk("flag_again", 16'(dut.rd_addr_loaded), 16'd1);

        // Abort after 6 data bits, then a clean frame
        frame(1'b0, 10'h155, 6, WRITE);
        chk("abort_flag", 16'(dut.rd_addr_loaded), 16'd1);
        tick();
        frame(1'b0, 10'h155, 10, WRITE);
        end_frame();

        // ss_n rising on the 10th-bit edge suppresses the strobe
        frame(1'b0, 10'h0F0, 9, WRITE);
        tick();
        chk("late_rxv", 16'(rx_valid), 16'd0);
        frame(1'b1, 10'h366, 10, READ_DATA);
        read_back(2, 8'h81, 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

SPI slave front-end and sequencer for the single-port command RAM. It deserialises MOSI frames into 10-bit RAM commands (`rx_data`/`rx_valid`). It tracks whether a read address has been loaded, and serialises RAM read data (`tx_data`/`tx_valid`) back onto MISO. It sits between the chip-level SPI pins and the RAM `din`/`dout` ports.

## Interface
- `ADDR_SIZE`, default 8: RAM address/data payload width. The command word is `ADDR_SIZE+2` bits.
- `clk` in 1: SPI clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ss_n` in 1: slave select, active-low; frame boundary.
- `mosi` in 1: serial data in, sampled on rising `clk`.
- `miso` out 1: serial data out, registered.
- `rx_data` out `ADDR_SIZE+2`: command word to RAM `din`. Bits [9:8] are the opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data); bits [7:0] are the payload.
- `rx_valid` out 1: one-cycle strobe, `rx_data` valid.
- `tx_data` in `ADDR_SIZE`: RAM read data.
- `tx_valid` in 1: RAM read data valid.

## Operation
- FSM states are IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal registers:
  - `rd_addr_loaded` flag
  - 4-bit bit counter
  - 10-bit RX shift register
  - 8-bit TX shift register
  - `done` flag (frame already issued)
- IDLE: go to CHK_CMD when `ss_n`=0 at an edge.
- CHK_CMD: sample `mosi` as the selector bit.
  - `mosi`=0 goes to WRITE.
  - `mosi`=1 with `rd_addr_loaded`=0 goes to READ_ADD.
  - `mosi`=1 with `rd_addr_loaded`=1 goes to READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift 10 `mosi` bits MSB-first into the RX register.
  - On the 10th bit, load `rx_data` and pulse `rx_valid` for exactly one cycle.
  - Then set `done`.
  - Further MOSI bits in the frame are ignored; there is never a second `rx_valid` per frame.
- READ_ADD: on the `rx_valid` pulse, set `rd_addr_loaded`.
- READ_DATA:
  - After `rx_valid`, wait for `tx_valid`=1. There is no timeout.
  - Capture `tx_data` into the TX register.
  - Drive 8 bits on `miso`, MSB first, one per cycle.
  - After the 8th bit, clear `rd_addr_loaded`.
  - `miso` returns to 0 and the FSM holds until `ss_n`=1.
- `ss_n`=1 in any state forces IDLE at the next edge.
  - Bit counter, `done` and TX-active are cleared.
  - `rd_addr_loaded` is unchanged unless its set/clear condition already completed.
  - An aborted partial frame produces no `rx_valid`.
- Opcode bits are forwarded unchecked. A selector/opcode mismatch is the master's error.
- `tx_valid` outside READ_DATA's wait phase is ignored.

## Timing
- Reset values: `miso`=0, `rx_valid`=0, `rx_data`=0. Internally: state=IDLE, `rd_addr_loaded`=0, counters 0.
- Edge E0 is the first edge with `ss_n`=0, giving IDLE→CHK_CMD.
- Selector bit sampled at E1.
- Data bits d9..d0 sampled at E2..E11.
- `rx_data`/`rx_valid` are registered at E11, so they are high during E11→E12.
- `rx_valid` is deasserted at E12.
- READ_DATA: if `tx_valid` is sampled high at edge Et, bit 7 of the data appears on `miso` after Et+1. Bits 6..0 follow on the next 7 edges.
- The RAM returns `tx_valid` one cycle after `rx_valid` with opcode 11. Nominal Et is E12, so MISO bit 7 appears at E13.
- `rst` asserted mid-frame clears all state immediately and asynchronously, with no `rx_valid` glitch.
- Simultaneous `ss_n` rise and 10th-bit edge: `ss_n`=1 wins. No `rx_valid` is issued and the state returns to IDLE.

## Structure
- Shared package `spi_ram_pkg`:
  - FSM state enum
  - opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11
  - frame length constant `CMD_BITS`=10
- One sub-module: `spi_tx_serializer`. It loads 8 bits on strobe, shifts MSB-first onto `miso` and asserts `tx_done` after 8 bits. The FSM, RX shifting and flag stay in the top.

## Test plan
- Reset: assert `rst` mid-WRITE frame, then release → `miso`=0, `rx_valid`=0, next frame decodes from IDLE cleanly.
- Write address: `ss_n`=0, send selector 0 + 10'b00_1010_0101 → single `rx_valid` at E11 with `rx_data`=10'h0A5.
- Write data then read back:
  - Send 0+10'h0A5, then 0+10'h13C.
  - Send 1+10'h2A5, which goes to READ_ADD and sets the flag.
  - Send 1+10'h300, which goes to READ_DATA. Model RAM returns 8'h3C with `tx_valid` 1 cycle later.
  - Required: `miso` shows 0,0,1,1,1,1,0,0 from E13, then the flag clears.
- Flag routing: two consecutive selector-1 frames → first goes to READ_ADD, second to READ_DATA; a third selector-1 frame goes to READ_ADD again.
- Abort: raise `ss_n` after 6 data bits → no `rx_valid`, state IDLE, `rd_addr_loaded` unchanged. Next full frame is correct.
- Delayed RAM: hold `tx_valid` low for 5 cycles in READ_DATA → `miso` stays 0 until 1 cycle after `tx_valid`, then 8 correct bits.
